// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX-stage training and status signals of the branch history table.
// The pipeline side uses master; the predictor uses slave.
interface branch_predictor_if;
    logic [31:0] IF_pc;
    logic [1:0]  IF_branch_prediction;
    logic        IF_predict_taken;
    logic        EX_Branch;
    logic [31:0] EX_pc;
    logic [1:0]  EX_branch_prediction;
    logic [1:0]  prediction_status;
    logic        ready;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output IF_pc, EX_Branch, EX_pc, EX_branch_prediction, prediction_status,
        input  IF_branch_prediction, IF_predict_taken, ready, branch_count, mispredict_count
    );

    modport slave (
        input  IF_pc, EX_Branch, EX_pc, EX_branch_prediction, prediction_status,
        output IF_branch_prediction, IF_predict_taken, ready, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Branch history table of 2-bit saturating counters with table-init FSM,
// training from resolved EX branches and branch/mispredict performance counters.
module branch_predictor #(
    parameter int unsigned INDEX_BITS   = 6,
    parameter logic [1:0]  INIT_COUNTER = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    branch_predictor_if.slave  bp
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] IDX_ONE = 1;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                state, state_nxt;
    logic                  ready_int;
    logic [INDEX_BITS-1:0] init_idx;
    logic [1:0]            bht [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic                  train, mispredict;
    logic [1:0]            old_val, trained_val;
    logic [31:0]           branch_cnt, mispredict_cnt;
    logic                  unused_pc_bits;

    assign rd_idx  = bp.IF_pc[INDEX_BITS+1:2];
    assign wr_idx  = bp.EX_pc[INDEX_BITS+1:2];
    assign old_val = bp.EX_branch_prediction;
    assign unused_pc_bits = ^{bp.IF_pc[31:INDEX_BITS+2], bp.IF_pc[1:0],
                              bp.EX_pc[31:INDEX_BITS+2], bp.EX_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_INIT;
        end else begin
            case (state)
                S_INIT:  if (init_idx == '1) state_nxt = S_READY;
                S_READY: state_nxt = S_READY;
                default: state_nxt = S_INIT;
            endcase
        end
    end

    always_comb begin
        ready_int = (state == S_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  init_idx <= '0;
        else if (clear)           init_idx <= '0;
        else if (state == S_INIT) init_idx <= init_idx + IDX_ONE;
    end

    // Clear outranks training; status 3 is reserved and never trains.
    assign train      = bp.EX_Branch & ready_int & ~clear & (bp.prediction_status != 2'd3);
    assign mispredict = (bp.prediction_status == 2'd0) | (bp.prediction_status == 2'd1);

    always_comb begin
        trained_val = old_val;
        case (bp.prediction_status)
            2'd0:    trained_val = (old_val == 2'b11) ? 2'b11 : old_val + 2'd1;
            2'd1:    trained_val = (old_val == 2'b00) ? 2'b00 : old_val - 2'd1;
            2'd2:    trained_val = old_val[1] ? 2'b11 : 2'b00;
            default: trained_val = old_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (state == S_INIT) bht[init_idx] <= INIT_COUNTER;
            else if (train)      bht[wr_idx]   <= trained_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (clear) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (train) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign bp.ready                = ready_int;
    assign bp.IF_branch_prediction = ready_int ? bht[rd_idx] : INIT_COUNTER;
    assign bp.IF_predict_taken     = bp.IF_branch_prediction[1] & ready_int;
    assign bp.branch_count         = branch_cnt;
    assign bp.mispredict_count     = mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed stimulus queues hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_branch_predictor;
    logic clk;
    logic rst;
    logic clear;

    branch_predictor_if bpi ();

    branch_predictor #(
        .INDEX_BITS   (6),
        .INIT_COUNTER (2'b01)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bp    (bpi)
    );

    typedef struct {
        string       name;
        logic [1:0]  pred;
        logic        taken;
        logic        rdy;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: compares every queued expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (bpi.IF_branch_prediction !== e.pred || bpi.IF_predict_taken !== e.taken ||
                    bpi.ready !== e.rdy || bpi.branch_count !== e.bc ||
                    bpi.mispredict_count !== e.mc) begin
                    errors++;
                    $display("FAIL %s: got pred=%b taken=%b ready=%b bc=%0d mc=%0d, want pred=%b taken=%b ready=%b bc=%0d mc=%0d",
                             e.name, bpi.IF_branch_prediction, bpi.IF_predict_taken, bpi.ready,
                             bpi.branch_count, bpi.mispredict_count,
                             e.pred, e.taken, e.rdy, e.bc, e.mc);
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [1:0] pred, input logic taken,
                            input logic rdy, input logic [31:0] bc, input logic [31:0] mc);
        exp_t e;
        e.name = name; e.pred = pred; e.taken = taken; e.rdy = rdy; e.bc = bc; e.mc = mc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [31:0] pc, input logic [1:0] pred, input logic [1:0] st);
        bpi.EX_Branch            = 1'b1;
        bpi.EX_pc                = pc;
        bpi.EX_branch_prediction = pred;
        bpi.prediction_status    = st;
    endtask

    task automatic idle();
        bpi.EX_Branch = 1'b0;
    endtask

    // After the first init interval: 64 intervals with ready=0, then ready=1.
    task automatic run_init(input string tag, input logic ex_while_init);
        for (int i = 1; i <= 65; i++) begin
            if (i > 1) step();
            bpi.IF_pc = 32'(i % 64) * 32'd4;
            if (ex_while_init && i == 30) ex(32'h40, 2'b01, 2'd0);
            else                          idle();
            push_exp($sformatf("%s_c%0d", tag, i), 2'b01, 1'b0, (i == 65), 32'd0, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        bpi.IF_pc = 32'h40; bpi.EX_Branch = 1'b0; bpi.EX_pc = '0;
        bpi.EX_branch_prediction = '0; bpi.prediction_status = '0;

        step(); step();
        push_exp("reset", 2'b01, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        rst = 1'b0;
        run_init("init", 1'b1);

        for (int i = 0; i < 64; i++) begin
            step();
            bpi.IF_pc = 32'(i) * 32'd4;
            push_exp($sformatf("scan_%0d", i), 2'b01, 1'b0, 1'b1, 32'd0, 32'd0);
        end

        // Basic increment and taken prediction
        step(); bpi.IF_pc = 32'h40; ex(32'h40, 2'b01, 2'd0);
        push_exp("t2_same", 2'b01, 1'b0, 1'b1, 32'd0, 32'd0);
        step(); idle();
        push_exp("t2_after", 2'b10, 1'b1, 1'b1, 32'd1, 32'd1);

        // Saturation and strengthening
        step(); bpi.IF_pc = 32'h44; ex(32'h44, 2'b11, 2'd2);
        push_exp("t3_sat_hi_pre", 2'b01, 1'b0, 1'b1, 32'd1, 32'd1);
        step(); idle();
        push_exp("t3_sat_hi", 2'b11, 1'b1, 1'b1, 32'd2, 32'd1);
        step(); bpi.IF_pc = 32'h48; ex(32'h48, 2'b00, 2'd1);
        step(); idle();
        push_exp("t3_sat_lo", 2'b00, 1'b0, 1'b1, 32'd3, 32'd2);
        step(); bpi.IF_pc = 32'h4C; ex(32'h4C, 2'b10, 2'd2);
        step(); idle();
        push_exp("t3_strong_t", 2'b11, 1'b1, 1'b1, 32'd4, 32'd2);
        step(); bpi.IF_pc = 32'h50; ex(32'h50, 2'b11, 2'd0);
        step(); idle();
        push_exp("t3_inc_sat", 2'b11, 1'b1, 1'b1, 32'd5, 32'd3);
        step(); bpi.IF_pc = 32'h54; ex(32'h54, 2'b10, 2'd1);
        step(); idle();
        push_exp("t3_dec", 2'b01, 1'b0, 1'b1, 32'd6, 32'd4);
        step(); bpi.IF_pc = 32'h58; ex(32'h58, 2'b01, 2'd2);
        step(); idle();
        push_exp("t3_strong_nt", 2'b00, 1'b0, 1'b1, 32'd7, 32'd4);
        // Entry 16 holds 10, but the carried 00 is what gets trained
        step(); bpi.IF_pc = 32'h40; ex(32'h40, 2'b00, 2'd0);
        step(); idle();
        push_exp("t3_carried", 2'b01, 1'b0, 1'b1, 32'd8, 32'd5);

        // Same-cycle read of the entry being written: no bypass
        step(); bpi.IF_pc = 32'h80; ex(32'h80, 2'b01, 2'd0);
        push_exp("t4_same_cycle", 2'b01, 1'b0, 1'b1, 32'd8, 32'd5);
        step(); idle();
        push_exp("t4_next", 2'b10, 1'b1, 1'b1, 32'd9, 32'd6);

        // Aliasing and reserved status
        step(); bpi.IF_pc = 32'h0; ex(32'h100, 2'b01, 2'd0);
        step(); idle();
        push_exp("t6_alias", 2'b10, 1'b1, 1'b1, 32'd10, 32'd7);
        step(); ex(32'h0, 2'b10, 2'd3);
        push_exp("t6_st3_pre", 2'b10, 1'b1, 1'b1, 32'd10, 32'd7);
        step(); idle();
        push_exp("t6_status3", 2'b10, 1'b1, 1'b1, 32'd10, 32'd7);

        // Clear during training, then reset mid-init
        step(); bpi.IF_pc = 32'h0; ex(32'h0, 2'b10, 2'd0); clear = 1'b1;
        push_exp("t5_clear_cycle", 2'b10, 1'b1, 1'b1, 32'd10, 32'd7);
        step(); clear = 1'b0; idle();
        push_exp("t5_after_clear", 2'b01, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 2; i <= 10; i++) begin
            step();
            push_exp($sformatf("t5_init_%0d", i), 2'b01, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        step(); rst = 1'b1; #1;
        push_exp("t5_rst", 2'b01, 1'b0, 1'b0, 32'd0, 32'd0);
        step(); rst = 1'b0;
        run_init("reinit", 1'b0);

        step(); bpi.IF_pc = 32'h0;
        push_exp("t5_entry0", 2'b01, 1'b0, 1'b1, 32'd0, 32'd0);
        step(); bpi.IF_pc = 32'h40;
        push_exp("t5_entry16", 2'b01, 1'b0, 1'b1, 32'd0, 32'd0);
        step(); bpi.IF_pc = 32'h80;
        push_exp("t5_entry32", 2'b01, 1'b0, 1'b1, 32'd0, 32'd0);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Branch history table (BHT) of 2-bit saturating counters. It supplies the 2-bit prediction carried down the pipe to the branch resolution unit as EX_branch_prediction. It consumes the unit's prediction_status to train the counters and keeps branch/mispredict performance counters. A table-initialisation FSM runs after reset or on a soft clear.

Parameters:
INDEX_BITS, 6, table has 2^INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2]
INIT_COUNTER, 2'b01, value written to every entry during init (weakly not taken)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous soft clear; restarts table init
IF_pc  input  32  fetch PC for lookup
IF_branch_prediction  output  2  counter value for IF_pc index (combinational read)
IF_predict_taken  output  1  IF_branch_prediction[1] & ready
EX_Branch  input  1  EX stage holds a resolved conditional branch
EX_pc  input  32  PC of the EX branch
EX_branch_prediction  input  2  counter value read for this branch at fetch, carried down pipe
prediction_status  input  2  0 = predicted NT/taken, 1 = predicted T/not taken, 2 = correct, 3 = reserved
ready  output  1  table initialised, predictions valid
branch_count  output  32  resolved branches since reset/clear
mispredict_count  output  32  mispredicts since reset/clear

Behaviour:
- Reset (async, rst=1): FSM=INIT, init_idx=0, ready=0, branch_count=0, mispredict_count=0; table contents don't-care until init completes.
- INIT: each cycle writes INIT_COUNTER to entry init_idx, then init_idx+1. On the cycle that writes entry 2^INDEX_BITS-1, next state is READY. Init takes exactly 2^INDEX_BITS cycles after rst deasserts.
- READY: ready=1. clear=1 in any state -> INIT with init_idx=0 next cycle, and both perf counters zeroed. rst or clear mid-INIT restarts from index 0.
- Lookup: IF_branch_prediction = table[IF_pc[INDEX_BITS+1:2]], zero latency. While ready=0, it outputs INIT_COUNTER and IF_predict_taken=0.
- Training occurs only when EX_Branch & ready & prediction_status!=3. The write index is EX_pc[INDEX_BITS+1:2]. The new value is computed from EX_branch_prediction (old = carried value, not a re-read of the table):
  - status 0 -> min(old+1, 3)
  - status 1 -> max(old-1, 0)
  - status 2 -> 2'b11 if old[1] else 2'b00 (strengthen)
- Status 3 with EX_Branch=1: no table write and no counter change.
- Write visible from the next cycle. Same-cycle IF read of the index being written returns the old value (no bypass).
- branch_count increments on every training event. mispredict_count increments on training events with status 0 or 1. Both saturate at 32'hFFFF_FFFF.
- clear takes priority over training in the same cycle: no write occurs and counters go to 0.
- EX_Branch while ready=0 is ignored: no write, no count.

Test Plan:
1. Release rst, IF_pc=0x40 -> ready=0 for 64 cycles, ready=1 on cycle 65; IF_branch_prediction=01 and IF_predict_taken=0 for every index.
2. EX_Branch=1, EX_pc=0x40, EX_branch_prediction=01, status=0 -> next cycle table[16]=10, IF_predict_taken=1 at IF_pc=0x40; mispredict_count=1, branch_count=1.
3. Saturation: EX_branch_prediction=11, status=2 -> entry stays 11. EX_branch_prediction=00, status=1 -> entry stays 00 (illegal combination, checks the clamp). EX_branch_prediction=10, status=2 -> 11.
4. Same cycle: EX_pc=IF_pc=0x80, update 01->10 -> IF_branch_prediction=01 that cycle, 10 next cycle.
5. Assert clear during training; also assert rst 10 cycles into init -> no write, counters=0, ready drops; init restarts at index 0 and completes 64 cycles later.
6. Aliasing: EX_pc=0x0 and 0x100 (INDEX_BITS=6) -> same entry 0 trained; status=3 -> no change; EX_Branch=1 while ready=0 -> no change.
